// File: rtl/debounce_oneshot.sv
// Switch conditioner: two-flop synchronizer, free-running sample prescaler and a
// four-state debounce FSM producing a clean level plus press/release one-shots.
`timescale 1ns/1ps
module debounce_oneshot #(
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_in,
  output logic level,
  output logic pulse,
  output logic release_pulse
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);

  localparam logic [DW-1:0] DIV_LAST    = DW'(TICK_DIV - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_TICKS - 1);

  localparam logic [1:0] S_LOW       = 2'd0;
  localparam logic [1:0] S_WAIT_HIGH = 2'd1;
  localparam logic [1:0] S_HIGH      = 2'd2;
  localparam logic [1:0] S_WAIT_LOW  = 2'd3;

  logic          sync1_q, sync1_d;
  logic          sw_s_q, sw_s_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    state_q, state_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic          release_pulse_q, release_pulse_d;
  logic          tick;

  always_comb begin
    sync1_d   = sw_in;
    sw_s_d    = sync1_q;
    tick      = (div_cnt_q == DIV_LAST);
    div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
  end

  // cnt holds the number of agreeing samples already taken in a WAIT state,
  // so cnt == STABLE_TICKS-1 means the current sample is the final one needed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick) begin
      case (state_q)
        S_LOW: begin
          if (sw_s_q) begin
            state_d = S_WAIT_HIGH;
            cnt_d   = CW'(1);
          end
        end
        S_WAIT_HIGH: begin
          if (!sw_s_q) begin
            state_d = S_LOW;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_HIGH: begin
          if (!sw_s_q) begin
            state_d = S_WAIT_LOW;
            cnt_d   = CW'(1);
          end
        end
        S_WAIT_LOW: begin
          if (sw_s_q) begin
            state_d = S_HIGH;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the new state.
  always_comb begin
    level_d         = (state_d == S_HIGH) || (state_d == S_WAIT_LOW);
    pulse_d         = (state_q == S_WAIT_HIGH) && (state_d == S_HIGH);
    release_pulse_d = (state_q == S_WAIT_LOW) && (state_d == S_LOW);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q         <= 1'b0;
      sw_s_q          <= 1'b0;
      div_cnt_q       <= '0;
      cnt_q           <= '0;
      state_q         <= S_LOW;
      level_q         <= 1'b0;
      pulse_q         <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      sync1_q         <= sync1_d;
      sw_s_q          <= sw_s_d;
      div_cnt_q       <= div_cnt_d;
      cnt_q           <= cnt_d;
      state_q         <= state_d;
      level_q         <= level_d;
      pulse_q         <= pulse_d;
      release_pulse_q <= release_pulse_d;
    end
  end

  assign level         = level_q;
  assign pulse         = pulse_q;
  assign release_pulse = release_pulse_q;

endmodule

// File: tb/tb_debounce_oneshot.sv
// Scoreboard bench for debounce_oneshot with TICK_DIV=4, STABLE_TICKS=3:
// scenarios queue expected edge events and level samples, a monitor compares.
`timescale 1ns/1ps
module tb_debounce_oneshot;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sw_in = 1'b0;
  logic level, pulse, release_pulse;

  debounce_oneshot #(.TICK_DIV(4), .STABLE_TICKS(3)) dut (
    .clk(clk),
    .reset(reset),
    .sw_in(sw_in),
    .level(level),
    .pulse(pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  // cyc == n during cycle n; cycle 0 opens at the last edge that samples reset high
  int cyc = 0;
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct { bit is_rel; int cyc; } ev_t;
  typedef struct { int cyc; bit lvl; } lv_t;
  ev_t ev_q[$];
  lv_t lv_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push_ev(input bit is_rel, input int c);
    ev_t e;
    e.is_rel = is_rel;
    e.cyc    = c;
    ev_q.push_back(e);
  endtask

  task automatic push_lv(input int c, input bit l);
    lv_t v;
    v.cyc = c;
    v.lvl = l;
    lv_q.push_back(v);
  endtask

  // Monitor: every observed one-shot must match the head of the event queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (pulse || release_pulse) begin
        check("pulse_exclusive", 32'(pulse && release_pulse), 32'd0);
        if (ev_q.size() == 0) begin
          check("unexpected_edge_pulse", {30'd0, pulse, release_pulse}, 32'd0);
        end else begin
          ev_t e;
          e = ev_q.pop_front();
          check("edge_kind_is_release", 32'(release_pulse), 32'(e.is_rel));
          check("edge_cycle", cyc, e.cyc);
        end
      end
      if (lv_q.size() > 0 && lv_q[0].cyc == cyc) begin
        lv_t v;
        v = lv_q.pop_front();
        check("level", 32'(level), 32'(v.lvl));
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset(input int k, input bit sw);
    @(negedge clk);
    reset = 1'b1;
    sw_in = sw;
    repeat (k) begin
      @(negedge clk);
      check("reset_level", 32'(level), 32'd0);
      check("reset_pulse", 32'(pulse), 32'd0);
      check("reset_release", 32'(release_pulse), 32'd0);
    end
    check("div_cnt_cycle0", 32'(dut.div_cnt_q), 32'd0);
    reset = 1'b0;
  endtask

  task automatic end_scn(input string name);
    check({name, "_events_left"}, ev_q.size(), 32'd0);
    check({name, "_levels_left"}, lv_q.size(), 32'd0);
    ev_q.delete();
    lv_q.delete();
  endtask

  initial begin
    // Clean press then release: samples 3,7,11 -> pulse 12; low samples 23,27,31 -> release 32
    push_ev(1'b0, 12);
    push_ev(1'b1, 32);
    push_lv(11, 1'b0); push_lv(12, 1'b1); push_lv(19, 1'b1);
    push_lv(31, 1'b1); push_lv(32, 1'b0); push_lv(40, 1'b0);
    do_reset(3, 1'b1);
    wait_cyc(20);
    sw_in = 1'b0;
    wait_cyc(45);
    end_scn("press_release");

    // Glitch high for cycles 1-5: enters WAIT_HIGH, aborts, never raises level
    push_lv(8, 1'b0); push_lv(12, 1'b0); push_lv(20, 1'b0);
    do_reset(2, 1'b0);
    wait_cyc(1);
    sw_in = 1'b1;
    wait_cyc(6);
    sw_in = 1'b0;
    wait_cyc(30);
    end_scn("glitch");

    // Reset at cycle 9 after two high samples; a fresh full debounce follows
    push_ev(1'b0, 12);
    push_lv(11, 1'b0); push_lv(12, 1'b1); push_lv(30, 1'b1);
    do_reset(2, 1'b1);
    wait_cyc(8);
    do_reset(1, 1'b1);
    wait_cyc(35);
    end_scn("reset_mid");

    // Long hold of 200 cycles: one pulse, level held, then one release at 212
    push_ev(1'b0, 12);
    push_ev(1'b1, 212);
    push_lv(12, 1'b1); push_lv(100, 1'b1); push_lv(199, 1'b1);
    push_lv(211, 1'b1); push_lv(212, 1'b0);
    do_reset(2, 1'b1);
    wait_cyc(200);
    sw_in = 1'b0;
    wait_cyc(220);
    end_scn("long_hold");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
